// File: rtl/f1_pkg.sv
// rtl/f1_pkg.sv - shared types, parameter defaults and width helper for the F1 start sequencer
package f1_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_DELAY,
        S_REACT,
        S_FAULT
    } f1_state_t;

    localparam int NUM_LIGHTS_DEF  = 10;
    localparam int RT_W_DEF        = 14;
    localparam int FLASH_TICKS_DEF = 250;

    function automatic int count_w(input int num_lights);
        return $clog2(num_lights + 1);
    endfunction

endpackage

// File: rtl/f1_sat_counter.sv
// rtl/f1_sat_counter.sv - tick counter with clear and enable; saturates at all-ones or wraps at WRAP_AT
module f1_sat_counter #(
    parameter int W       = 8,
    parameter bit WRAP    = 1'b0,
    parameter int WRAP_AT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] LIMIT = WRAP ? W'(WRAP_AT) : {W{1'b1}};

    assign sat = (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (!sat)
                cnt <= cnt + 1'b1;
            else if (WRAP)
                cnt <= '0;
        end
    end

endmodule

// File: rtl/f1_start_seq_ctrl.sv
// rtl/f1_start_seq_ctrl.sv - F1 start lights, random hold, reaction timing and jump-start detect (F1_FAULT_FLASH_EN: flash lamps in FAULT)
module f1_start_seq_ctrl
    import f1_pkg::*;
#(
    parameter int NUM_LIGHTS  = NUM_LIGHTS_DEF,
    parameter int RT_W        = RT_W_DEF,
    parameter int FLASH_TICKS = FLASH_TICKS_DEF
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  trigger,
    input  logic                  time_out,
    input  logic                  press,
    output logic                  en_lfsr,
    output logic                  start_delay,
    output logic [NUM_LIGHTS-1:0] ledr,
    output logic [RT_W-1:0]       reaction,
    output logic                  reaction_valid,
    output logic                  jump_start,
    output logic                  busy
);

    localparam int CW = count_w(NUM_LIGHTS);
    localparam logic [NUM_LIGHTS-1:0] TOP_LAMP = NUM_LIGHTS'(1) << (NUM_LIGHTS - 1);

    f1_state_t       state;
    logic [CW-1:0]   count;
    logic [RT_W-1:0] rt_cnt;
    logic            rt_sat;
    logic            flash_toggle;

    assign busy = (state != S_IDLE);

    // Cleared throughout DELAY, so it is already zero when time_out enters REACT.
    f1_sat_counter #(.W(RT_W), .WRAP(1'b0)) u_rt_cnt (
        .clk   (sysclk),
        .rst_n (rst_n),
        .clr   (state != S_REACT),
        .en    ((state == S_REACT) && tick && !press),
        .cnt   (rt_cnt),
        .sat   (rt_sat)
    );

`ifdef F1_FAULT_FLASH_EN
    localparam int FW = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
    logic [FW-1:0] flash_cnt;
    logic          flash_wrap;
    logic          unused_flash;

    f1_sat_counter #(.W(FW), .WRAP(1'b1), .WRAP_AT(FLASH_TICKS - 1)) u_flash_cnt (
        .clk   (sysclk),
        .rst_n (rst_n),
        .clr   (state != S_FAULT),
        .en    ((state == S_FAULT) && tick),
        .cnt   (flash_cnt),
        .sat   (flash_wrap)
    );
    assign unused_flash = ^flash_cnt;
    assign flash_toggle = tick && flash_wrap;
`else
    assign flash_toggle = 1'b0;
`endif

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            count          <= '0;
            ledr           <= '0;
            reaction       <= '0;
            reaction_valid <= 1'b0;
            start_delay    <= 1'b0;
            jump_start     <= 1'b0;
            en_lfsr        <= 1'b1;
        end else begin
            reaction_valid <= 1'b0;
            start_delay    <= 1'b0;
            // A press during the light-up or hold beats any tick or time_out in the same cycle.
            if ((state == S_COUNT || state == S_DELAY) && press) begin
                state      <= S_FAULT;
                ledr       <= '1;
                jump_start <= 1'b1;
                en_lfsr    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        ledr    <= '0;
                        en_lfsr <= 1'b1;
                        if (trigger) begin
                            state <= S_COUNT;
                            count <= '0;
                        end
                    end
                    S_COUNT: begin
                        if (count == CW'(NUM_LIGHTS)) begin
                            state       <= S_DELAY;
                            start_delay <= 1'b1;
                            en_lfsr     <= 1'b0;
                        end else if (tick) begin
                            ledr  <= TOP_LAMP | (ledr >> 1);
                            count <= count + 1'b1;
                        end
                    end
                    S_DELAY: begin
                        if (time_out) begin
                            state <= S_REACT;
                            ledr  <= '0;
                        end
                    end
                    S_REACT: begin
                        if (press) begin
                            state          <= S_IDLE;
                            reaction       <= rt_cnt;
                            reaction_valid <= 1'b1;
                            en_lfsr        <= 1'b1;
                        end else if (tick && rt_sat) begin
                            state          <= S_IDLE;
                            reaction       <= '1;
                            reaction_valid <= 1'b1;
                            en_lfsr        <= 1'b1;
                        end
                    end
                    S_FAULT: begin
                        if (trigger) begin
                            state      <= S_IDLE;
                            ledr       <= '0;
                            count      <= '0;
                            jump_start <= 1'b0;
                            en_lfsr    <= 1'b1;
                        end else if (flash_toggle) begin
                            ledr <= ~ledr;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_f1_start_seq_ctrl.sv
// tb/tb_f1_start_seq_ctrl.sv - directed-vector bench for f1_start_seq_ctrl
module tb_f1_start_seq_ctrl;

    logic sysclk = 1'b0;
    logic rst_n, tick, trigger, time_out, press;

    logic        en_lfsr, start_delay, reaction_valid, jump_start, busy;
    logic [9:0]  ledr;
    logic [13:0] reaction;

    logic       en_lfsr_s, start_delay_s, reaction_valid_s, jump_start_s, busy_s;
    logic [1:0] ledr_s;
    logic [3:0] reaction_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 sysclk = ~sysclk;

    f1_start_seq_ctrl #(.NUM_LIGHTS(10), .RT_W(14), .FLASH_TICKS(3)) dut (
        .sysclk         (sysclk),
        .rst_n          (rst_n),
        .tick           (tick),
        .trigger        (trigger),
        .time_out       (time_out),
        .press          (press),
        .en_lfsr        (en_lfsr),
        .start_delay    (start_delay),
        .ledr           (ledr),
        .reaction       (reaction),
        .reaction_valid (reaction_valid),
        .jump_start     (jump_start),
        .busy           (busy)
    );

    f1_start_seq_ctrl #(.NUM_LIGHTS(2), .RT_W(4), .FLASH_TICKS(3)) dut_s (
        .sysclk         (sysclk),
        .rst_n          (rst_n),
        .tick           (tick),
        .trigger        (trigger),
        .time_out       (time_out),
        .press          (press),
        .en_lfsr        (en_lfsr_s),
        .start_delay    (start_delay_s),
        .ledr           (ledr_s),
        .reaction       (reaction_s),
        .reaction_valid (reaction_valid_s),
        .jump_start     (jump_start_s),
        .busy           (busy_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge sysclk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
        end
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
    endtask

    task automatic pulse_time_out();
        time_out = 1'b1;
        cyc();
        time_out = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic run_to_delay();
        pulse_trigger();
        ticks(10);
        cyc();
    endtask

    initial begin
        logic [9:0] exp_ledr;
        tick = 1'b0; trigger = 1'b0; time_out = 1'b0; press = 1'b0;
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("rst_ledr", ledr, 0);
        chk("rst_en_lfsr", en_lfsr, 1);
        chk("rst_busy", busy, 0);
        chk("rst_reaction", reaction, 0);
        chk("rst_start_delay", start_delay, 0);
        chk("rst_jump_start", jump_start, 0);
        chk("rst_valid", reaction_valid, 0);
        rst_n = 1'b1;
        cyc();

        // normal start
        pulse_trigger();
        chk("count_busy", busy, 1);
        exp_ledr = 10'h000;
        for (int i = 0; i < 10; i++) begin
            exp_ledr = (exp_ledr >> 1) | 10'h200;
            ticks(1);
            chk($sformatf("lamp%0d", i), ledr, exp_ledr);
            chk($sformatf("lamp%0d_sd", i), start_delay, 0);
        end
        chk("en_lfsr_count", en_lfsr, 1);
        cyc();
        chk("start_delay_pulse", start_delay, 1);
        chk("en_lfsr_delay", en_lfsr, 0);
        cyc();
        chk("start_delay_once", start_delay, 0);
        chk("delay_lamps", ledr, 10'h3FF);
        pulse_time_out();
        chk("lights_out", ledr, 0);
        ticks(187);
        chk("no_valid_yet", reaction_valid, 0);
        press = 1'b1;
        cyc();
        press = 1'b0;
        chk("reaction_187", reaction, 187);
        chk("valid_pulse", reaction_valid, 1);
        cyc();
        chk("valid_drop", reaction_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_en_lfsr", en_lfsr, 1);

        // jump start after 4 lamps
        pulse_trigger();
        ticks(4);
        chk("four_lamps", ledr, 10'h3C0);
        press = 1'b1;
        cyc();
        press = 1'b0;
        chk("jump_flag", jump_start, 1);
        chk("jump_ledr", ledr, 10'h3FF);
        chk("jump_reaction_kept", reaction, 187);
        chk("jump_no_valid", reaction_valid, 0);
        ticks(2);
        chk("fault_ledr_t2", ledr, 10'h3FF);
        ticks(1);
`ifdef F1_FAULT_FLASH_EN
        chk("flash_off", ledr, 10'h000);
        ticks(2);
        chk("flash_off_t5", ledr, 10'h000);
        ticks(1);
        chk("flash_on", ledr, 10'h3FF);
`else
        chk("steady_t3", ledr, 10'h3FF);
        ticks(3);
        chk("steady_t6", ledr, 10'h3FF);
`endif
        pulse_trigger();
        chk("fault_exit_ledr", ledr, 0);
        chk("fault_exit_busy", busy, 0);
        chk("fault_exit_jump", jump_start, 0);

        // press together with time_out
        run_to_delay();
        press = 1'b1;
        time_out = 1'b1;
        cyc();
        press = 1'b0;
        time_out = 1'b0;
        chk("tie_timeout_fault", jump_start, 1);
        pulse_trigger();
        chk("tie_timeout_idle", busy, 0);

        // press together with tick at rt_cnt=5
        run_to_delay();
        pulse_time_out();
        ticks(5);
        tick = 1'b1;
        press = 1'b1;
        cyc();
        tick = 1'b0;
        press = 1'b0;
        chk("tie_tick_reaction", reaction, 5);
        chk("tie_tick_valid", reaction_valid, 1);

        // asynchronous reset in DELAY
        cyc();
        run_to_delay();
        chk("pre_reset_ledr", ledr, 10'h3FF);
        #2 rst_n = 1'b0;
        #1;
        chk("async_ledr", ledr, 0);
        chk("async_busy", busy, 0);
        cyc();
        rst_n = 1'b1;
        pulse_trigger();
        ticks(1);
        chk("restart_lamp", ledr, 10'h200);

        // saturation on the RT_W=4 instance
        do_reset();
        pulse_trigger();
        ticks(2);
        chk("s_lamps", ledr_s, 2'b11);
        cyc();
        chk("s_start_delay", start_delay_s, 1);
        pulse_time_out();
        chk("s_react_ledr", ledr_s, 0);
        ticks(15);
        chk("s_not_done", reaction_valid_s, 0);
        chk("s_busy", busy_s, 1);
        ticks(1);
        chk("s_reaction_sat", reaction_s, 15);
        chk("s_valid", reaction_valid_s, 1);
        cyc();
        chk("s_idle", busy_s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
